lfsr_prng_stream: RTL
=====================

LFSR_PRNG_STREAM -- requirements
Module: lfsr_prng_stream

Interface
REQ-001 Parameter LFSR_WIDTH, default 32, state register width; legal range 4..128.
REQ-002 Parameter TAPS, default 32'h8020_0003, feedback mask of LFSR_WIDTH bits; bit i set means state bit i feeds the XOR.
REQ-003 Parameter STEP, default 8, LFSR shifts per generated word; legal range 1..LFSR_WIDTH.
REQ-004 Parameter OUT_WIDTH, default 16, output word width; legal range 1..LFSR_WIDTH.
REQ-005 Parameter DEFAULT_SEED, default 1, reset and lockup-recovery state; SHALL be nonzero.
REQ-006 Parameter CNT_WIDTH, default 32, width of the word counter.
REQ-007 clk  in  1  clock; all logic on the rising edge.
REQ-008 resetn  in  1  synchronous, active-low reset.
REQ-009 enable  in  1  when high in RUN, permits generation of new words.
REQ-010 seed_valid  in  1  seed offer.
REQ-011 seed_ready  out  1  constant 1; a seed is accepted on any cycle with seed_valid=1.
REQ-012 seed  in  LFSR_WIDTH  seed value.
REQ-013 out_valid  out  1  out_data holds an unconsumed word.
REQ-014 out_ready  in  1  consumer accepts the word.
REQ-015 out_data  out  OUT_WIDTH  generated word.
REQ-016 word_count  out  CNT_WIDTH  number of accepted output handshakes since the last seed or reset.
REQ-017 lockup  out  1  single-cycle pulse when the all-zero state is replaced by DEFAULT_SEED.
REQ-018 running  out  1  high when the FSM is in RUN.

Function
REQ-019 Single step: f(s) = {s[LFSR_WIDTH-2:0], ^(s & TAPS)}, a Fibonacci shift-left step with feedback into bit 0.
REQ-020 Advance: A(s) = f applied STEP times, fully unrolled, so the block generates one word per clock.
REQ-021 FSM states: IDLE and RUN; IDLE -> RUN on seed acceptance; RUN -> RUN on seed acceptance; no other transitions except reset.
REQ-022 Seed accept cycle: state <= seed, or DEFAULT_SEED with a lockup pulse if seed==0; out_valid <= 0; word_count <= 0; FSM <= RUN.
REQ-023 Generation fires in RUN when enable=1, no seed is accepted, and (out_valid=0 or out_ready=1). On firing: state <= A(state), out_data <= A(state)[OUT_WIDTH-1:0], out_valid <= 1.
REQ-024 Runtime lockup: if A(state)==0 on a firing cycle, state <= DEFAULT_SEED, out_data <= DEFAULT_SEED[OUT_WIDTH-1:0], and lockup pulses.
REQ-025 If out_valid=1, out_ready=1 and generation does not fire, out_valid <= 0.
REQ-026 When out_valid=1 and out_ready=0, out_data and out_valid hold stable regardless of enable.
REQ-027 word_count increments on each out_valid and out_ready handshake and wraps from all-ones to 0. A seed accepted in the same cycle wins: the handshake completes but the count is reset to 0.
REQ-028 Latency: a seed accepted at cycle N with enable=1 gives out_valid=1 at N+2 with out_data=A(seed)[OUT_WIDTH-1:0].
REQ-029 In IDLE, out_valid=0, state is held, and enable is ignored.

Reset
REQ-030 With resetn=0 at a clock edge: FSM=IDLE, state=DEFAULT_SEED, out_valid=0, out_data=0, word_count=0, lockup=0, running=0.
REQ-031 Reset mid-operation discards any pending word; reset has priority over the seed and output handshakes.

Verification
REQ-032 Params W=4, TAPS=4'h9, STEP=1, OUT=4; seed 1, out_ready=1, enable=1 -> out_data sequence 3,7,F,E,D,A,5,B,6,C,9,2,4,8,1,3; period 15; word_count=15 after 15 handshakes.
REQ-033 Same params with STEP=2, seed 1 -> out_data sequence 7,E,A,B,C,2,8,3,F,D,5,6,9,4,1.
REQ-034 Backpressure: out_ready=0 for 5 cycles after the first word 3 -> out_data stays 3 and out_valid stays 1; after release the next word is 7 with no word skipped.
REQ-035 Zero seed with DEFAULT_SEED=1 -> lockup pulses for exactly one cycle at the accept edge, and the sequence then matches REQ-032.
REQ-036 Reseed while out_valid=1 and out_ready=1 -> word_count=0 at the next cycle, out_valid=0 for one cycle, then out_data=A(new seed).
REQ-037 Reset asserted mid-stream -> all REQ-030 values appear at the next edge; out_valid stays 0 until a seed is accepted.

Source files
------------

// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream
//   Seedable Fibonacci LFSR that produces one OUT_WIDTH-bit word per clock
//   behind a valid/ready output handshake. Each generated word advances the
//   LFSR by STEP single-bit shifts, fully unrolled into one combinational
//   stage. An all-zero state (from a zero seed or from the advance itself)
//   is replaced by DEFAULT_SEED, and lockup pulses for one cycle.
//
// Ports
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   enable     allows word generation while running
//   seed_valid seed offer; always accepted (seed_ready is tied high)
//   seed_ready constant 1
//   seed       new LFSR state
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word
//   out_data   generated word (low OUT_WIDTH bits of the advanced state)
//   word_count output handshakes since the last seed or reset (wraps)
//   lockup     one-cycle pulse when the zero state was replaced
//   running    FSM is in RUN
module lfsr_prng_stream #(
    parameter int                    LFSR_WIDTH   = 32,
    parameter logic [LFSR_WIDTH-1:0] TAPS         = LFSR_WIDTH'(32'h8020_0003),
    parameter int                    STEP         = 8,
    parameter int                    OUT_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = LFSR_WIDTH'(1),
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  lockup,
    output logic                  running
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t                  fsm;
    logic [LFSR_WIDTH-1:0] state;
    logic [LFSR_WIDTH-1:0] nxt;
    logic                  fire;
    logic                  hs;

    // STEP shift-left steps with XOR-of-taps feedback into bit 0.
    function automatic logic [LFSR_WIDTH-1:0] advance(input logic [LFSR_WIDTH-1:0] s);
        logic [LFSR_WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < STEP; i++) begin
            t = {t[LFSR_WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    assign nxt        = advance(state);
    assign seed_ready = 1'b1;
    assign running    = (fsm == RUN);
    assign hs         = out_valid & out_ready;
    // A seed this cycle pre-empts generation; a stalled word is never overwritten.
    assign fire       = (fsm == RUN) & enable & ~seed_valid & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm        <= IDLE;
            state      <= DEFAULT_SEED;
            out_valid  <= 1'b0;
            out_data   <= '0;
            word_count <= '0;
            lockup     <= 1'b0;
        end else begin
            lockup <= 1'b0;
            if (seed_valid) begin
                // Any handshake in this cycle still completes, but the count restarts.
                fsm        <= RUN;
                out_valid  <= 1'b0;
                word_count <= '0;
                if (seed == '0) begin
                    state  <= DEFAULT_SEED;
                    lockup <= 1'b1;
                end else begin
                    state  <= seed;
                end
            end else begin
                if (hs) begin
                    word_count <= word_count + CNT_WIDTH'(1);
                end
                if (fire) begin
                    out_valid <= 1'b1;
                    if (nxt == '0) begin
                        state    <= DEFAULT_SEED;
                        out_data <= DEFAULT_SEED[OUT_WIDTH-1:0];
                        lockup   <= 1'b1;
                    end else begin
                        state    <= nxt;
                        out_data <= nxt[OUT_WIDTH-1:0];
                    end
                end else if (hs) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
